// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants, register map and FSM encoding for the keyboard scan controller
package kbd_pkg;
   localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   // event word is {ext, brk, code}; DATA exposes it at the same bit positions
   localparam int EV_W   = 10;
   localparam int EV_EXT = 9;
   localparam int EV_BRK = 8;

   localparam int ST_NONEMPTY = 0;
   localparam int ST_COUNT    = 8;
   localparam int ST_FULL     = 16;
   localparam int DATA_VALID  = 31;
   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_FLUSH  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      WAIT = 2'd2
   } state_t;
endpackage

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - DEPTH x 10-bit key event FIFO with push, pop and flush
module kbd_event_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic [EV_W-1:0] din,
   input  logic            pop,
   input  logic            flush,
   output logic [EV_W-1:0] dout,
   output logic            full,
   output logic            empty,
   output logic [AW:0]     count
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [EV_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         if (do_push & ~do_pop)      count <= count + (AW+1)'(1);
         else if (~do_push & do_pop) count <= count - (AW+1)'(1);
      end
   end
endmodule

// File: rtl/kbd_scan_ctrl.sv
// rtl/kbd_scan_ctrl.sv - drains the PS/2 receiver, folds E0/F0 prefixes into key events, exposes them as registers
module kbd_scan_ctrl
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        kb_ready,
   input  logic [7:0]  kb_data,
   output logic        kb_rdn,
   input  logic        reg_sel,
   input  logic [1:0]  reg_a,
   input  logic        reg_rd,
   input  logic        reg_wr,
   input  logic [31:0] reg_wd,
   output logic [31:0] reg_rdata,
   output logic        irq
);
   state_t          state;
   state_t          state_next;
   logic            enable;
   logic            irq_en;
   logic            ext;
   logic            brk;
   logic            ctrl_wr;
   logic            flush;
   logic            data_rd;
   logic            is_ext;
   logic            is_brk;
   logic            push;
   logic [EV_W-1:0] head;
   logic            full;
   logic            empty;
   logic [AW:0]     count;
   logic            unused_wd;

   assign ctrl_wr   = reg_sel & reg_wr & (reg_a == REG_CTRL);
   assign flush     = ctrl_wr & reg_wd[CTRL_FLUSH];
   assign data_rd   = reg_sel & reg_rd & (reg_a == REG_DATA);
   assign is_ext    = (kb_data == KB_PREFIX_EXT);
   assign is_brk    = (kb_data == KB_PREFIX_BRK);
   assign push      = (state == POP) & ~is_ext & ~is_brk;
   assign unused_wd = ^reg_wd[31:3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // full is the registered FIFO flag, so a same-cycle CPU pop never admits a new byte
   always_comb begin
      state_next = state;
      kb_rdn     = 1'b1;
      case (state)
         IDLE: if (enable & kb_ready & ~full) state_next = POP;
         POP: begin
            kb_rdn     = 1'b0;
            state_next = WAIT;
         end
         WAIT:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable <= 1'b1;
         irq_en <= 1'b0;
         ext    <= 1'b0;
         brk    <= 1'b0;
         irq    <= 1'b0;
      end else begin
         irq <= irq_en & ~empty;
         if (ctrl_wr) begin
            enable <= reg_wd[CTRL_ENABLE];
            irq_en <= reg_wd[CTRL_IRQ_EN];
         end
         // a flush racing a POP discards the byte and leaves the prefix flags clear
         if (flush) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (state == POP) begin
            if (is_ext)      ext <= 1'b1;
            else if (is_brk) brk <= 1'b1;
            else begin
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
      end
   end

   kbd_event_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({ext, brk, kb_data}),
      .pop   (data_rd),
      .flush (flush),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      reg_rdata = '0;
      case (reg_a)
         REG_STATUS: begin
            reg_rdata[ST_NONEMPTY]       = ~empty;
            reg_rdata[ST_COUNT +: AW+1]  = count;
            reg_rdata[ST_FULL]           = full;
         end
         REG_DATA: begin
            if (!empty) begin
               reg_rdata[DATA_VALID]  = 1'b1;
               reg_rdata[EV_W-1:0]    = head;
            end
         end
         REG_CTRL: begin
            reg_rdata[CTRL_ENABLE] = enable;
            reg_rdata[CTRL_IRQ_EN] = irq_en;
         end
         default: reg_rdata = '0;
      endcase
   end
endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb/tb_kbd_scan_ctrl.sv - directed and randomized bench for kbd_scan_ctrl against a queue-based event model
module tb_kbd_scan_ctrl;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        kb_ready = 1'b0;
   logic [7:0]  kb_data = 8'h00;
   logic        kb_rdn;
   logic        reg_sel = 1'b0;
   logic [1:0]  reg_a = 2'd0;
   logic        reg_rd = 1'b0;
   logic        reg_wr = 1'b0;
   logic [31:0] reg_wd = 32'h0;
   logic [31:0] reg_rdata;
   logic        irq;

   always #5 clk = ~clk;

   kbd_scan_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .kb_ready  (kb_ready),
      .kb_data   (kb_data),
      .kb_rdn    (kb_rdn),
      .reg_sel   (reg_sel),
      .reg_a     (reg_a),
      .reg_rd    (reg_rd),
      .reg_wr    (reg_wr),
      .reg_wd    (reg_wd),
      .reg_rdata (reg_rdata),
      .irq       (irq)
   );

   int nvec = 0;
   int nerr = 0;

   logic [7:0] rx_q[$];
   logic [9:0] ev_q[$];
   logic m_ext = 1'b0, m_brk = 1'b0, m_en = 1'b1, m_irq_en = 1'b0, m_irq = 1'b0;
   int   cyc = 0, last_pulse = -100, pulses = 0, prev_sz = 0;
   logic prev_en = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rdata(input logic [1:0] a);
      logic [31:0] r;
      int sz;
      sz = ev_q.size();
      r  = 32'h0;
      case (a)
         2'd0: r = 32'(sz != 0) | (32'(sz) << 8) | (32'(sz == DEPTH) << 16);
         2'd1: if (sz != 0) r = {1'b1, 21'b0, ev_q[0]};
         2'd2: r = {30'b0, m_irq_en, m_en};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic rx_drive();
      kb_ready = (rx_q.size() != 0);
      kb_data  = kb_ready ? rx_q[0] : 8'h00;
   endtask

   task automatic step();
      logic       rdn_low;
      logic [7:0] b;
      int         sz;
      logic       fl;
      @(negedge clk);
      check("rdata", reg_rdata, exp_rdata(reg_a));
      check("irq", irq, m_irq);
      rdn_low = ~kb_rdn;
      b       = kb_data;
      if (rdn_low) begin
         check("pop_ready", kb_ready, 1);
         check("pop_gap", cyc - last_pulse >= 3, 1);
         check("pop_allowed", (prev_sz < DEPTH) && prev_en, 1);
         last_pulse = cyc;
         pulses++;
      end
      sz = ev_q.size();
      @(posedge clk);
      prev_sz = sz;
      prev_en = m_en;
      m_irq   = m_irq_en && (sz != 0);
      fl = reg_sel && reg_wr && (reg_a == 2'd2) && reg_wd[2];
      if (reg_sel && reg_wr && reg_a == 2'd2) begin
         m_en     = reg_wd[0];
         m_irq_en = reg_wd[1];
      end
      if (fl) begin
         ev_q.delete();
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else begin
         if (reg_sel && reg_rd && reg_a == 2'd1 && sz != 0) void'(ev_q.pop_front());
         if (rdn_low) begin
            if (b == 8'hE0)      m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
               ev_q.push_back({m_ext, m_brk, b});
               m_ext = 1'b0;
               m_brk = 1'b0;
            end
         end
      end
      cyc++;
      #1;
      if (rdn_low) void'(rx_q.pop_front());
      reg_sel = 1'b0;
      reg_rd  = 1'b0;
      reg_wr  = 1'b0;
      rx_drive();
   endtask

   task automatic rd_pop();
      reg_sel = 1'b1; reg_rd = 1'b1; reg_a = 2'd1;
      step();
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      reg_sel = 1'b1; reg_wr = 1'b1; reg_a = 2'd2; reg_wd = v;
      step();
   endtask

   task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string tag);
      reg_a = a;
      #1;
      check(tag, reg_rdata, exp);
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_q.push_back(b);
      rx_drive();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int op;
      logic [7:0] btab [4];
      btab[0] = 8'hE0; btab[1] = 8'hF0; btab[2] = 8'hE1; btab[3] = 8'h00;

      rx_drive();
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdn", kb_rdn, 1);
      check("rst_irq", irq, 0);
      peek(2'd0, 32'h0, "rst_status");
      peek(2'd2, 32'h1, "rst_ctrl");
      rst_n = 1'b1;

      // build up irq, then reset while a POP is in flight
      wr_ctrl(32'h3);
      rx_push(8'h44);
      repeat (6) step();
      check("pre_rst_irq", irq, 1);
      rx_push(8'h33);
      for (int i = 0; i < 8; i++) begin
         if (kb_rdn === 1'b0) break;
         step();
      end
      check("reach_pop", kb_rdn, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdn", kb_rdn, 1);
      check("mid_rst_irq", irq, 0);
      peek(2'd0, 32'h0, "mid_rst_status");
      peek(2'd2, 32'h1, "mid_rst_ctrl");
      ev_q.delete(); rx_q.delete(); rx_drive();
      m_ext = 0; m_brk = 0; m_en = 1; m_irq_en = 0; m_irq = 0;
      last_pulse = -100; prev_sz = 0; prev_en = 1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single make code
      p0 = pulses;
      rx_push(8'h1C);
      repeat (8) step();
      check("one_pulse", pulses - p0, 1);
      peek(2'd0, 32'h101, "status_1c");
      peek(2'd1, 32'h8000001C, "data_1c");
      rd_pop();
      peek(2'd0, 32'h0, "status_after_1c");

      // extended break
      p0 = pulses;
      rx_push(8'hE0); rx_push(8'hF0); rx_push(8'h74);
      repeat (15) step();
      check("three_pulses", pulses - p0, 3);
      peek(2'd0, 32'h101, "status_e0f074");
      peek(2'd1, 32'h80000374, "data_e0f074");
      rd_pop();

      // backpressure at DEPTH
      p0 = pulses;
      for (int i = 1; i <= 9; i++) rx_push(8'(i));
      repeat (40) step();
      check("full_pulses", pulses - p0, 8);
      check("full_rdn_high", kb_rdn, 1);
      check("rx_left", rx_q.size(), 1);
      peek(2'd0, 32'h10801, "status_full");
      peek(2'd1, 32'h80000001, "data_head_01");
      rd_pop();
      repeat (3) step();
      check("refill_pulse", pulses - p0, 9);
      peek(2'd0, 32'h10801, "status_refull");
      repeat (8) rd_pop();
      peek(2'd0, 32'h0, "status_drained");

      // flush between prefix and code
      p0 = pulses;
      rx_push(8'hE0);
      repeat (4) step();
      check("e0_pulse", pulses - p0, 1);
      wr_ctrl(32'h5);
      rx_push(8'h1C);
      repeat (8) step();
      peek(2'd1, 32'h8000001C, "data_flushed_ext");
      peek(2'd2, 32'h1, "ctrl_flush_selfclr");
      rd_pop();

      // flush landing on the POP of a code byte
      rx_push(8'hE0); rx_push(8'h2A);
      for (int i = 0; i < 12; i++) begin
         if (kb_rdn === 1'b0 && kb_data === 8'h2A) break;
         step();
      end
      check("reach_pop_2a", kb_data, 8'h2A);
      wr_ctrl(32'h5);
      repeat (4) step();
      peek(2'd0, 32'h0, "status_flush_pop");
      check("rx_consumed", rx_q.size(), 0);
      rx_push(8'h3B);
      repeat (6) step();
      peek(2'd1, 32'h8000003B, "data_after_flush_pop");
      rd_pop();

      // concurrent push and pop with interrupts on
      wr_ctrl(32'h3);
      rx_push(8'h15); rx_push(8'h16);
      repeat (8) step();
      peek(2'd0, 32'h201, "status_two");
      check("irq_two", irq, 1);
      rx_push(8'h17);
      for (int i = 0; i < 6; i++) begin
         if (kb_rdn === 1'b0) break;
         step();
      end
      check("reach_pop_17", kb_rdn, 0);
      rd_pop();
      peek(2'd0, 32'h201, "status_push_pop");
      check("irq_push_pop", irq, 1);
      rd_pop();
      rd_pop();
      check("irq_lag", irq, 1);
      step();
      check("irq_drop", irq, 0);
      wr_ctrl(32'h1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0 && rx_q.size() < 6) begin
            btab[3] = 8'($urandom);
            rx_push(btab[$urandom_range(0, 3)]);
         end
         op = $urandom_range(0, 7);
         reg_wd = $urandom;
         case (op)
            0, 1: begin reg_sel = 1; reg_rd = 1; reg_a = 2'd1; end
            2: begin reg_sel = 1; reg_rd = 1; reg_a = 2'($urandom_range(0, 3)); end
            3: begin
               reg_sel = 1; reg_wr = 1; reg_a = 2'd2;
               reg_wd[0] = ($urandom_range(0, 4) != 0);
               reg_wd[1] = 1'($urandom);
               reg_wd[2] = ($urandom_range(0, 5) == 0);
            end
            4: begin reg_sel = 1; reg_wr = 1; reg_a = 2'd3; end
            default: reg_a = 2'($urandom_range(0, 3));
         endcase
         step();
      end

      wr_ctrl(32'h1);
      for (int i = 0; i < 200; i++) begin
         if (rx_q.size() == 0 && ev_q.size() == 0) break;
         if (i % 2 == 0) rd_pop();
         else step();
      end
      check("drain_rx", rx_q.size(), 0);
      peek(2'd0, 32'h0, "drain_status");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
